// File: rtl/ysyx_25030093_wbu_if.sv
// Writeback-unit bus: upstream result handshake, register-file write port
// and the retire handshake towards the IFU.
interface ysyx_25030093_wbu_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_rd;
   logic                  in_rd_wen;
   logic [1:0]            in_sel;
   logic [DATA_WIDTH-1:0] in_alu_res;
   logic [DATA_WIDTH-1:0] in_load_raw;
   logic [DATA_WIDTH-1:0] in_csr_rdata;
   logic [2:0]            in_load_op;
   logic [1:0]            in_addr_lo;
   logic [DATA_WIDTH-1:0] in_pc;
   logic [DATA_WIDTH-1:0] in_next_pc;
   logic                  rf_wen;
   logic [ADDR_WIDTH-1:0] rf_waddr;
   logic [DATA_WIDTH-1:0] rf_wdata;
   logic                  commit_valid;
   logic                  commit_ready;
   logic [DATA_WIDTH-1:0] commit_pc;
   logic [DATA_WIDTH-1:0] commit_next_pc;
   logic [63:0]           retire_cnt;

   modport master (
      output in_valid, in_rd, in_rd_wen, in_sel, in_alu_res, in_load_raw,
             in_csr_rdata, in_load_op, in_addr_lo, in_pc, in_next_pc, commit_ready,
      input  in_ready, rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc,
             commit_next_pc, retire_cnt
   );

   modport slave (
      input  in_valid, in_rd, in_rd_wen, in_sel, in_alu_res, in_load_raw,
             in_csr_rdata, in_load_op, in_addr_lo, in_pc, in_next_pc, commit_ready,
      output in_ready, rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc,
             commit_next_pc, retire_cnt
   );
endinterface

// File: rtl/ysyx_25030093_wbu.sv
// Writeback unit: latches one result, writes the register file for one cycle,
// then holds the retire handshake until the IFU takes it.
module ysyx_25030093_wbu #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input logic                clk,
   input logic                rst,
   ysyx_25030093_wbu_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WRITE       = 2'd1,
      WAIT_COMMIT = 2'd2
   } state_t;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] rd_reg;
   logic                  rd_wen_reg;
   logic [1:0]            sel_reg;
   logic [DATA_WIDTH-1:0] alu_reg, load_raw_reg, csr_reg, pc_reg, next_pc_reg;
   logic [2:0]            load_op_reg;
   logic [1:0]            addr_lo_reg;
   logic [63:0]           retire_cnt_reg;

   logic                  in_ready, rf_wen, commit_valid, accept, commit_fire;
   logic [7:0]            load_byte;
   logic [15:0]           load_half;
   logic [DATA_WIDTH-1:0] load_data, wdata;

   always_comb begin
      state_next   = state_reg;
      in_ready     = 1'b0;
      rf_wen       = 1'b0;
      commit_valid = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) state_next = WRITE;
         end
         WRITE: begin
            // x0 is hard-wired; the instruction still retires.
            rf_wen       = rd_wen_reg & (rd_reg != '0);
            commit_valid = 1'b1;
            state_next   = bus.commit_ready ? IDLE : WAIT_COMMIT;
         end
         WAIT_COMMIT: begin
            commit_valid = 1'b1;
            if (bus.commit_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept      = bus.in_valid & in_ready;
   assign commit_fire = commit_valid & bus.commit_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         rd_reg         <= '0;
         rd_wen_reg     <= 1'b0;
         sel_reg        <= 2'b00;
         alu_reg        <= '0;
         load_raw_reg   <= '0;
         csr_reg        <= '0;
         pc_reg         <= '0;
         next_pc_reg    <= '0;
         load_op_reg    <= 3'b000;
         addr_lo_reg    <= 2'b00;
         retire_cnt_reg <= 64'd0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            rd_reg       <= bus.in_rd;
            rd_wen_reg   <= bus.in_rd_wen;
            sel_reg      <= bus.in_sel;
            alu_reg      <= bus.in_alu_res;
            load_raw_reg <= bus.in_load_raw;
            csr_reg      <= bus.in_csr_rdata;
            pc_reg       <= bus.in_pc;
            next_pc_reg  <= bus.in_next_pc;
            load_op_reg  <= bus.in_load_op;
            addr_lo_reg  <= bus.in_addr_lo;
         end
         if (commit_fire) retire_cnt_reg <= retire_cnt_reg + 64'd1;
      end
   end

   // Alignment is not checked: halves ignore addr_lo[0], words ignore addr_lo.
   always_comb begin
      load_byte = load_raw_reg[7:0];
      case (addr_lo_reg)
         2'd0: load_byte = load_raw_reg[7:0];
         2'd1: load_byte = load_raw_reg[15:8];
         2'd2: load_byte = load_raw_reg[23:16];
         2'd3: load_byte = load_raw_reg[31:24];
         default: load_byte = load_raw_reg[7:0];
      endcase
      load_half = addr_lo_reg[1] ? load_raw_reg[31:16] : load_raw_reg[15:0];
      case (load_op_reg)
         3'b000:  load_data = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
         3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, load_byte};
         3'b001:  load_data = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
         3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, load_half};
         default: load_data = load_raw_reg;
      endcase
   end

   always_comb begin
      wdata = alu_reg;
      case (sel_reg)
         2'b00: wdata = alu_reg;
         2'b01: wdata = load_data;
         2'b10: wdata = pc_reg + DATA_WIDTH'(4);
         2'b11: wdata = csr_reg;
         default: wdata = alu_reg;
      endcase
   end

   assign bus.in_ready       = in_ready;
   assign bus.rf_wen         = rf_wen;
   assign bus.rf_waddr       = rd_reg;
   assign bus.rf_wdata       = wdata;
   assign bus.commit_valid   = commit_valid;
   assign bus.commit_pc      = pc_reg;
   assign bus.commit_next_pc = next_pc_reg;
   assign bus.retire_cnt     = retire_cnt_reg;
endmodule

// File: tb/tb_ysyx_25030093_wbu.sv
// Directed + random bench for the writeback unit with an expectation queue.
module tb_ysyx_25030093_wbu;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ysyx_25030093_wbu_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

   ysyx_25030093_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic [31:0] npc;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_mis = 0;
   int          n_txn = 0;
   logic [63:0] cnt_model = 64'd0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_wdata(input logic [1:0] sel, input logic [31:0] alu,
                                               input logic [31:0] raw, input logic [31:0] csr,
                                               input logic [2:0] op, input logic [1:0] lo,
                                               input logic [31:0] pc);
      logic [31:0] sh;
      logic [31:0] hs;
      logic [31:0] r;
      sh = raw >> (8 * lo);
      hs = raw >> (16 * lo[1]);
      case (sel)
         2'b00: r = alu;
         2'b10: r = pc + 32'd4;
         2'b11: r = csr;
         default: begin
            case (op)
               3'b000:  r = {{24{sh[7]}}, sh[7:0]};
               3'b100:  r = {24'd0, sh[7:0]};
               3'b001:  r = {{16{hs[15]}}, hs[15:0]};
               3'b101:  r = {16'd0, hs[15:0]};
               default: r = raw;
            endcase
         end
      endcase
      return r;
   endfunction

   task automatic scramble_inputs();
      bus.in_rd        = 5'($urandom);
      bus.in_rd_wen    = 1'($urandom);
      bus.in_sel       = 2'($urandom);
      bus.in_alu_res   = $urandom;
      bus.in_load_raw  = $urandom;
      bus.in_csr_rdata = $urandom;
      bus.in_load_op   = 3'($urandom);
      bus.in_addr_lo   = 2'($urandom);
      bus.in_pc        = $urandom;
      bus.in_next_pc   = $urandom;
   endtask

   task automatic run_txn(input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] raw, input logic [31:0] csr,
                          input logic [2:0] op, input logic [1:0] lo, input logic [31:0] pc,
                          input logic [31:0] exp_wdata, input int stall);
      exp_t e;
      exp_t got;
      @(posedge clk); #1;
      bus.in_rd = rd;  bus.in_rd_wen = wen;  bus.in_sel = sel;
      bus.in_alu_res = alu;  bus.in_load_raw = raw;  bus.in_csr_rdata = csr;
      bus.in_load_op = op;  bus.in_addr_lo = lo;  bus.in_pc = pc;
      bus.in_next_pc = pc ^ 32'h0000_0F00;
      bus.in_valid = 1'b1;
      bus.commit_ready = (stall == 0);
      e.wen = wen && (rd != 5'd0);
      e.waddr = rd;  e.wdata = exp_wdata;  e.pc = pc;  e.npc = pc ^ 32'h0000_0F00;
      sb.push_back(e);
      @(negedge clk);
      check("in_ready_before_accept", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      scramble_inputs();
      @(negedge clk);
      check("commit_valid_write", bus.commit_valid, 1'b1);
      if (sb.size() == 0) begin
         check("scoreboard_nonempty", 64'd0, 64'd1);
      end else begin
         got = sb.pop_front();
         check("rf_wen_write", bus.rf_wen, got.wen);
         check("rf_waddr", bus.rf_waddr, got.waddr);
         check("rf_wdata", bus.rf_wdata, got.wdata);
         check("commit_pc", bus.commit_pc, got.pc);
         check("commit_next_pc", bus.commit_next_pc, got.npc);
         check("in_ready_write", bus.in_ready, 1'b0);
         for (int i = 1; i <= stall; i++) begin
            @(posedge clk); #1;
            if (i == stall) bus.commit_ready = 1'b1;
            @(negedge clk);
            check("rf_wen_wait", bus.rf_wen, 1'b0);
            check("commit_valid_wait", bus.commit_valid, 1'b1);
            check("commit_pc_wait", bus.commit_pc, got.pc);
            check("rf_wdata_wait", bus.rf_wdata, got.wdata);
            check("in_ready_wait", bus.in_ready, 1'b0);
         end
      end
      @(posedge clk); #1;
      bus.commit_ready = 1'b0;
      cnt_model = cnt_model + 64'd1;
      @(negedge clk);
      check("in_ready_after", bus.in_ready, 1'b1);
      check("commit_valid_after", bus.commit_valid, 1'b0);
      check("retire_cnt", bus.retire_cnt, cnt_model);
      n_txn++;
      $display("txn %0d: sel=%0d rd=%0d wen=%0d wdata=%h pc=%h stall=%0d", n_txn, sel, rd,
               wen, exp_wdata, pc, stall);
   endtask

   initial begin
      logic [1:0]  r_sel;
      logic [31:0] r_alu, r_raw, r_csr, r_pc;
      logic [2:0]  r_op;
      logic [1:0]  r_lo;
      logic [4:0]  r_rd;
      logic        r_wen;

      bus.in_valid = 1'b0;
      bus.commit_ready = 1'b0;
      scramble_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready", bus.in_ready, 1'b1);
      check("reset_rf_wen", bus.rf_wen, 1'b0);
      check("reset_commit_valid", bus.commit_valid, 1'b0);
      check("reset_rf_waddr", bus.rf_waddr, 5'd0);
      check("reset_rf_wdata", bus.rf_wdata, 32'd0);
      check("reset_commit_pc", bus.commit_pc, 32'd0);
      check("reset_commit_next_pc", bus.commit_next_pc, 32'd0);
      check("reset_retire_cnt", bus.retire_cnt, 64'd0);

      // commit_ready while idle must not count
      @(posedge clk); #1 bus.commit_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 bus.commit_ready = 1'b0;
      @(negedge clk);
      check("idle_ready_no_count", bus.retire_cnt, 64'd0);

      run_txn(5'd5, 1'b1, 2'b00, 32'h1234, 32'h0, 32'h0, 3'b000, 2'd0, 32'h8000_0000,
              32'h0000_1234, 0);
      run_txn(5'd6, 1'b1, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 3'b000, 2'd3, 32'h8000_0004,
              32'hFFFF_FF80, 0);
      run_txn(5'd7, 1'b1, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 3'b100, 2'd1, 32'h8000_0008,
              32'h0000_007F, 1);
      run_txn(5'd8, 1'b1, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 3'b001, 2'd2, 32'h8000_000C,
              32'hFFFF_80FF, 0);
      run_txn(5'd9, 1'b1, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 3'b101, 2'd0, 32'h8000_0010,
              32'h0000_7F01, 0);
      run_txn(5'd10, 1'b1, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 3'b010, 2'd3, 32'h8000_0014,
              32'h80FF_7F01, 0);
      run_txn(5'd0, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 3'b000, 2'd0, 32'h8000_0018,
              32'hDEAD_BEEF, 0);
      run_txn(5'd11, 1'b1, 2'b00, 32'h0000_00AA, 32'h0, 32'h0, 3'b000, 2'd0, 32'h8000_001C,
              32'h0000_00AA, 3);
      run_txn(5'd1, 1'b1, 2'b10, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 32'hFFFF_FFFC,
              32'h0000_0000, 0);
      run_txn(5'd12, 1'b1, 2'b11, 32'h0, 32'h0, 32'hCAFE_F00D, 3'b000, 2'd0, 32'h8000_0020,
              32'hCAFE_F00D, 0);
      run_txn(5'd13, 1'b0, 2'b00, 32'h5555_5555, 32'h0, 32'h0, 3'b000, 2'd0, 32'h8000_0024,
              32'h5555_5555, 0);

      for (int k = 0; k < 12; k++) begin
         r_sel = 2'($urandom);  r_alu = $urandom;  r_raw = $urandom;  r_csr = $urandom;
         r_op = 3'($urandom);   r_lo = 2'($urandom);  r_pc = $urandom;
         r_rd = 5'($urandom);   r_wen = 1'($urandom);
         run_txn(r_rd, r_wen, r_sel, r_alu, r_raw, r_csr, r_op, r_lo, r_pc,
                 model_wdata(r_sel, r_alu, r_raw, r_csr, r_op, r_lo, r_pc),
                 int'($urandom_range(0, 2)));
      end

      // reset while waiting for commit aborts the instruction
      @(posedge clk); #1;
      bus.in_rd = 5'd3;  bus.in_rd_wen = 1'b1;  bus.in_sel = 2'b00;
      bus.in_alu_res = 32'h7777_0000;  bus.in_pc = 32'h4000_0000;
      bus.in_valid = 1'b1;  bus.commit_ready = 1'b0;
      @(posedge clk); #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check("abort_write_commit_valid", bus.commit_valid, 1'b1);
      check("abort_write_rf_wdata", bus.rf_wdata, 32'h7777_0000);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("abort_wait_commit_valid", bus.commit_valid, 1'b1);
      @(posedge clk); #1 rst = 1'b0;
      cnt_model = 64'd0;
      @(negedge clk);
      check("abort_commit_valid", bus.commit_valid, 1'b0);
      check("abort_in_ready", bus.in_ready, 1'b1);
      check("abort_retire_cnt", bus.retire_cnt, cnt_model);
      check("abort_rf_wen", bus.rf_wen, 1'b0);
      check("abort_commit_pc", bus.commit_pc, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_no_pulse", bus.rf_wen, 1'b0);
      check("abort_still_idle", bus.commit_valid, 1'b0);

      run_txn(5'd4, 1'b1, 2'b00, 32'h0000_0042, 32'h0, 32'h0, 3'b000, 2'd0, 32'h8000_0100,
              32'h0000_0042, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/ysyx_25030093_wbu.md
YSYX_25030093_WBU -- requirements
Module: ysyx_25030093_wbu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register-file address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, datapath width; load extraction logic is defined for 32 only.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset: synchronous, active-high.
REQ-005 in_valid  in  1  upstream (EXU/LSU) result valid.
REQ-006 in_ready  out  1  WBU can accept a result.
REQ-007 in_rd  in  ADDR_WIDTH  destination register.
REQ-008 in_rd_wen  in  1  instruction writes rd.
REQ-009 in_sel  in  2  result source: 00 ALU, 01 LOAD, 10 PC+4, 11 CSR.
REQ-010 in_alu_res / in_load_raw / in_csr_rdata  in  DATA_WIDTH each  candidate results; in_load_raw is the aligned memory word.
REQ-011 in_load_op  in  3  load funct3; in_addr_lo  in  2  load address bits [1:0].
REQ-012 in_pc / in_next_pc  in  DATA_WIDTH each  PC of the instruction and its successor.
REQ-013 rf_wen  out  1; rf_waddr  out  ADDR_WIDTH; rf_wdata  out  DATA_WIDTH  register-file write port.
REQ-014 commit_valid  out  1; commit_ready  in  1; commit_pc, commit_next_pc  out  DATA_WIDTH  retire handshake to IFU.
REQ-015 retire_cnt  out  64  retired-instruction count.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, WAIT_COMMIT.
REQ-017 in_ready SHALL be 1 only in IDLE; input accept = in_valid & in_ready.
REQ-018 On accept, all in_* fields SHALL be registered; next state WRITE. Otherwise IDLE is held.
REQ-019 In WRITE: rf_wen = latched in_rd_wen & (latched rd != 0), asserted for exactly this one cycle; commit_valid = 1.
REQ-020 WRITE -> IDLE if commit_ready, else -> WAIT_COMMIT.
REQ-021 WAIT_COMMIT: commit_valid = 1, rf_wen = 0; stays until commit_ready, then -> IDLE.
REQ-022 Result latency: accept at cycle N -> rf_wen/commit_valid at cycle N+1; next accept no earlier than cycle N+2.
REQ-023 rf_waddr, rf_wdata, commit_pc, commit_next_pc SHALL be driven from latched values and held stable while commit_valid = 1.
REQ-024 rf_wdata per in_sel: ALU -> in_alu_res; PC+4 -> in_pc + 4, modulo 2^DATA_WIDTH; CSR -> in_csr_rdata; LOAD -> per REQ-025.
REQ-025 LOAD extraction: 000 LB = sign-extend byte at bits [8*addr_lo+7 : 8*addr_lo]; 100 LBU = same byte, zero-extended; 001 LH = sign-extend half selected by addr_lo[1]; 101 LHU = same half, zero-extended; 010 LW = full word; any other code = full word.
REQ-026 Misaligned addresses SHALL NOT be checked: LH/LHU ignore addr_lo[0]; LW ignores addr_lo.
REQ-027 retire_cnt SHALL increment by 1 on each cycle where commit_valid & commit_ready, wrapping at 2^64 - 1 -> 0.
REQ-028 commit_ready while in IDLE SHALL have no effect.
REQ-029 in_valid, and any change of in_* fields, while not in IDLE SHALL be ignored; upstream must hold in_* until accepted.

Reset
REQ-030 With rst = 1 at a posedge: state -> IDLE, retire_cnt -> 0, all latched fields -> 0.
REQ-031 Outputs after reset: in_ready = 1, rf_wen = 0, commit_valid = 0, rf_waddr = 0, rf_wdata = 0, commit_pc = 0, commit_next_pc = 0.
REQ-032 rst asserted in WRITE or WAIT_COMMIT SHALL abort the instruction: no further rf_wen pulse, no count increment, IDLE on the next cycle.
REQ-033 rst SHALL take priority over any accept or commit handshake in the same cycle.

Verification
REQ-034 ALU write, commit_ready held 1: in_sel = 00, rd = 5, alu = 0x1234 -> next cycle rf_wen = 1, waddr = 5, wdata = 0x1234; retire_cnt 0 -> 1; in_ready returns to 1 on the following cycle.
REQ-035 Loads with in_load_raw = 0x80FF7F01:
- LB, addr_lo = 3 -> 0xFFFFFF80
- LBU, addr_lo = 1 -> 0x0000007F
- LH, addr_lo = 2 -> 0xFFFF80FF
- LHU, addr_lo = 0 -> 0x00007F01
REQ-036 rd = 0 with in_rd_wen = 1 -> rf_wen stays 0; commit still occurs; retire_cnt increments.
REQ-037 commit_ready held 0 for 3 cycles -> rf_wen pulses only in the first cycle; commit_valid = 1 for 4 cycles with stable commit_pc; in_ready = 0 throughout.
REQ-038 JAL writeback: in_sel = 10, pc = 0xFFFFFFFC -> wdata = 0x00000000 (wrap).
REQ-039 rst asserted during WAIT_COMMIT -> next cycle commit_valid = 0, in_ready = 1, retire_cnt = 0.
